// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider for MIPS DIV/DIVU, one division in flight.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the 32 steps via a DIVZERO state.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        div_stall_o,
  output logic [1:0]  debugState
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DONE    = 2'd2
`ifdef DIV_ZERO_FAST_EN
    ,
    DIVZERO = 2'd3
`endif
  } stateT;

  stateT       state;
  stateT       stateNext;
  logic [4:0]  stepCnt;
  logic [63:0] work;
  logic [31:0] divisorMag;
  logic        isSigned;
  logic        dividendNeg;
  logic        divisorNeg;
`ifdef DIV_ZERO_FAST_EN
  logic [31:0] dividendRaw;
`endif

  logic        op1Neg;
  logic        op2Neg;
  logic [31:0] op1Mag;
  logic [31:0] op2Mag;
  logic [32:0] shiftedRem;
  logic [32:0] trial;
  logic [31:0] newRem;
  logic [31:0] newQuo;
  logic [31:0] quoFixed;
  logic [31:0] remFixed;

  // Handshake: start_i is a level held by E while div_stall_o is high; the
  // request is consumed when ready_o pulses (one cycle, result_o valid).
  // annul_i drops any request at the next edge and no ready_o is produced.
  assign div_stall_o = start_i & ~ready_o & ~annul_i;

  always_comb begin
    op1Neg = signed_i & opdata1_i[31];
    op2Neg = signed_i & opdata2_i[31];
    op1Mag = op1Neg ? (~opdata1_i + 32'd1) : opdata1_i;
    op2Mag = op2Neg ? (~opdata2_i + 32'd1) : opdata2_i;
  end

  // work holds {rem[31:0], quo}; the 33rd remainder bit only lives in the
  // trial subtraction since the restored remainder is always below the divisor.
  always_comb begin
    shiftedRem = work[63:31];
    trial      = shiftedRem - {1'b0, divisorMag};
    newRem     = trial[32] ? shiftedRem[31:0] : trial[31:0];
    newQuo     = {work[30:0], ~trial[32]};
    quoFixed   = (isSigned && (dividendNeg != divisorNeg)) ? (~newQuo + 32'd1) : newQuo;
    remFixed   = (isSigned && dividendNeg) ? (~newRem + 32'd1) : newRem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    if (annul_i) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
`ifdef DIV_ZERO_FAST_EN
            stateNext = (opdata2_i == 32'd0) ? DIVZERO : BUSY;
`else
            stateNext = BUSY;
`endif
          end
        end
        BUSY: begin
          if (stepCnt == 5'd31) begin
            stateNext = DONE;
          end
        end
        DONE: stateNext = IDLE;
`ifdef DIV_ZERO_FAST_EN
        DIVZERO: stateNext = DONE;
`endif
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o    = (state == DONE);
    debugState = state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stepCnt     <= 5'd0;
      work        <= 64'd0;
      divisorMag  <= 32'd0;
      isSigned    <= 1'b0;
      dividendNeg <= 1'b0;
      divisorNeg  <= 1'b0;
      result_o    <= 64'd0;
`ifdef DIV_ZERO_FAST_EN
      dividendRaw <= 32'd0;
`endif
    end else if (!annul_i) begin
      case (state)
        IDLE: begin
          if (start_i) begin
            isSigned    <= signed_i;
            dividendNeg <= op1Neg;
            divisorNeg  <= op2Neg;
            divisorMag  <= op2Mag;
            work        <= {32'd0, op1Mag};
            stepCnt     <= 5'd0;
`ifdef DIV_ZERO_FAST_EN
            dividendRaw <= opdata1_i;
`endif
          end
        end
        BUSY: begin
          work    <= {newRem, newQuo};
          stepCnt <= stepCnt + 5'd1;
          if (stepCnt == 5'd31) begin
            result_o <= {remFixed, quoFixed};
          end
        end
`ifdef DIV_ZERO_FAST_EN
        DIVZERO: result_o <= {dividendRaw, 32'hFFFFFFFF};
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: directed cases from the MIPS DIV/DIVU behaviour plus randomized
// divisions, aborts and resets checked against an arithmetic model every cycle.
module tb_div_iter;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        div_stall_o;
  logic [1:0]  debugState;

  div_iter dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .div_stall_o (div_stall_o),
    .debugState  (debugState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lastReadyCyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // reference model: plain arithmetic
  function automatic logic [63:0] refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'd0) begin
      if (FAST || !sgn) return {a, 32'hFFFFFFFF};
      return {a, (a[31] ? 32'h00000001 : 32'hFFFFFFFF)};
    end
    if (!sgn) return {a % b, a / b};
    la = longint'(signed'(a));
    lb = longint'(signed'(b));
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int latOf(input logic [31:0] b);
    return (FAST && b == 32'd0) ? 2 : 33;
  endfunction

  // scoreboard: cycles remaining until the pending result is due
  logic [63:0] expQ[$];
  int          remaining = 0;
  bit          expReady = 1'b0;
  logic [63:0] heldRes = 64'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining = 0;
      expReady = 1'b0;
      heldRes = 64'd0;
      expQ.delete();
    end else if (annul_i) begin
      remaining = 0;
      expReady = 1'b0;
      expQ.delete();
    end else if (expReady) begin
      expReady = 1'b0;
    end else if (remaining == 0) begin
      if (start_i) begin
        expQ.push_back(refDiv(signed_i, opdata1_i, opdata2_i));
        remaining = latOf(opdata2_i) - 1;
      end
    end else begin
      remaining--;
      if (remaining == 0) begin
        expReady = 1'b1;
        heldRes = expQ.pop_front();
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    #2;
    chk("ready_o", {63'd0, ready_o}, {63'd0, expReady});
    chk("div_stall_o", {63'd0, div_stall_o}, {63'd0, start_i & ~expReady & ~annul_i});
    chk("result_o", result_o, heldRes);
  end

  // driver: called at a falling edge; returns one falling edge after ready_o with start_i still high
  task automatic doDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input bit checkLit, input logic [63:0] lit, input string name);
    int c;
    int stallCnt;
    int lat;
    start_i = 1'b1;
    signed_i = sgn;
    opdata1_i = a;
    opdata2_i = b;
    annul_i = 1'b0;
    lat = latOf(b);
    c = 0;
    stallCnt = 0;
    forever begin
      #1;
      if (div_stall_o) stallCnt++;
      if (ready_o) break;
      if (c > 100) break;
      @(negedge clk);
      c++;
    end
    chk({name, " latency"}, 64'(c), 64'(lat));
    chk({name, " stall cycles"}, 64'(stallCnt), 64'(lat));
    if (checkLit) chk(name, result_o, lit);
    lastReadyCyc = cyc;
    @(negedge clk);
  endtask

  function automatic logic [31:0] randOp();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic abortDiv();
    int k;
    start_i = 1'b1;
    signed_i = 1'($urandom_range(0, 1));
    opdata1_i = randOp();
    opdata2_i = randOp();
    k = $urandom_range(1, 30);
    repeat (k) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] prev;
    int r1;
    int r2;
    rst = 1'b1;
    start_i = 1'b0;
    signed_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    annul_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset result_o", result_o, 64'd0);
    chk("reset ready_o", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    doDiv(1'b0, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, "divu 100/7");
    start_i = 1'b0;
    @(negedge clk);
    doDiv(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, "div -7/2");
    doDiv(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, "div overflow");
    doDiv(1'b0, 32'd5, 32'd0, 1'b1, {32'd5, 32'hFFFFFFFF}, "divu 5/0");
`ifdef DIV_ZERO_FAST_EN
    doDiv(1'b1, 32'hFFFFFFFB, 32'd0, 1'b1, {32'hFFFFFFFB, 32'hFFFFFFFF}, "div -5/0");
`else
    doDiv(1'b1, 32'hFFFFFFFB, 32'd0, 1'b1, {32'hFFFFFFFB, 32'h00000001}, "div -5/0");
`endif
    start_i = 1'b0;
    repeat (2) @(negedge clk);

    // back-to-back
    doDiv(1'b0, 32'd1000, 32'd10, 1'b1, {32'd0, 32'd100}, "b2b first");
    r1 = lastReadyCyc;
    doDiv(1'b0, 32'd12345, 32'd100, 1'b1, {32'd45, 32'd123}, "b2b second");
    r2 = lastReadyCyc;
    chk("b2b spacing", 64'(r2 - r1), 64'd34);
    start_i = 1'b0;
    @(negedge clk);

    // annul at T+10
    start_i = 1'b1;
    signed_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    repeat (10) @(negedge clk);
    prev = result_o;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    #1;
    chk("annul ready_o", {63'd0, ready_o}, 64'd0);
    chk("annul result held", result_o, prev);
    @(negedge clk);
    doDiv(1'b0, 32'd9, 32'd3, 1'b1, {32'd0, 32'd3}, "divu 9/3 after annul");
    start_i = 1'b0;
    @(negedge clk);

    // reset mid-BUSY
    start_i = 1'b1;
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    start_i = 1'b0;
    #1;
    chk("mid-busy reset result_o", result_o, 64'd0);
    chk("mid-busy reset ready_o", {63'd0, ready_o}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    doDiv(1'b0, 32'd1, 32'd1, 1'b1, {32'd0, 32'd1}, "divu 1/1 after reset");
    start_i = 1'b0;
    @(negedge clk);

    // randomized
    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        abortDiv();
      end else begin
        doDiv(1'($urandom_range(0, 1)), randOp(), randOp(), 1'b0, 64'd0, "random");
        if ($urandom_range(0, 2) != 0) begin
          start_i = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    end
    start_i = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
